cell_update_serial: RTL
=======================

CELL_UPDATE_SERIAL -- requirements
Module: cell_update_serial

Interface
REQ-001 SHALL have parameter BIRTH_COUNT, default 3: neighbour count that turns a dead cell alive.
REQ-002 SHALL have parameter SURVIVE_MIN, default 2: lowest neighbour count at which a live cell survives.
REQ-003 SHALL have parameter SURVIVE_MAX, default 3: highest neighbour count at which a live cell survives.
REQ-004 SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1, synchronous active-low reset.
REQ-006 SHALL have port START, input, 1, begins a new cell evaluation; sampled only in IDLE.
REQ-007 SHALL have port CELL_STATE, input, 1, current cell state (1 = alive), captured with START.
REQ-008 SHALL have port NBR_VALID, input, 1, NBR_BIT is valid.
REQ-009 SHALL have port NBR_BIT, input, 1, one neighbour state per accepted beat.
REQ-010 SHALL have port NBR_READY, output, 1, block accepts a neighbour beat.
REQ-011 SHALL have port NEXT_VALID, output, 1, NEXT_STATE is valid.
REQ-012 SHALL have port NEXT_STATE, output, 1, computed next-generation cell state.
REQ-013 SHALL have port NEXT_READY, input, 1, downstream accepts the result.
REQ-014 SHALL have port BUSY, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM and RESULT.
REQ-016 SHALL, in IDLE with START=1, capture CELL_STATE, clear the beat counter and neighbour count to 0, and enter ACCUM on the next cycle.
REQ-017 SHALL ignore START in ACCUM and RESULT.
REQ-018 SHALL drive NBR_READY=1 only in ACCUM.
REQ-019 SHALL count a beat as accepted only when NBR_VALID=1 and NBR_READY=1 in the same cycle, and SHALL add NBR_BIT to a 4-bit neighbour count (range 0..8, no overflow possible).
REQ-020 SHALL, on the 8th accepted beat, register NEXT_STATE and enter RESULT; with NBR_VALID held high, START in cycle t gives NEXT_VALID=1 in cycle t+9.
REQ-021 SHALL set NEXT_STATE=1 if (alive and SURVIVE_MIN<=count<=SURVIVE_MAX) or (dead and count==BIRTH_COUNT); otherwise 0. The count includes the 8th beat's bit.
REQ-022 SHALL hold NEXT_VALID=1 and a stable NEXT_STATE in RESULT until NEXT_VALID and NEXT_READY are both 1, then enter IDLE.
REQ-023 SHALL NOT assert NEXT_VALID outside RESULT.
REQ-024 SHALL stall ACCUM indefinitely while NBR_VALID=0, with the counters unchanged.
REQ-025 SHALL NOT start a new evaluation in the cycle of the RESULT handshake; the earliest START is sampled in the following IDLE cycle.

Reset
REQ-026 SHALL, when RESET_N=0 at a clock edge, enter IDLE from any state, abandon any partial evaluation, and clear the count and beat counters.
REQ-027 SHALL give these output values in reset and after it: NBR_READY=0, NEXT_VALID=0, NEXT_STATE=0, BUSY=0, COUNT=0.

Configuration
REQ-028 SHALL, when CELL_COUNT_OUT_EN is defined, add port COUNT (output, 4 bits) carrying the live neighbour count, updated on each accepted beat and held through RESULT.
REQ-029 SHALL, without CELL_COUNT_OUT_EN, omit the COUNT port and leave all other behaviour identical.

Structure
REQ-030 SHALL take the FSM state enum, NEIGHBOR_COUNT=8 and COUNT_W=4 from the shared package conway_pkg.
REQ-031 SHALL put the birth/survive decision in one combinational sub-module, cell_rule_eval (inputs count and alive; output next state).

Verification
REQ-032 SHALL check: alive cell, neighbour beats 1,1,0,0,0,0,0,0 with NBR_VALID held high -> NEXT_VALID at t+9, NEXT_STATE=1, COUNT=2.
REQ-033 SHALL check: dead cell, three 1s in eight beats -> NEXT_STATE=1; dead cell, two 1s -> NEXT_STATE=0.
REQ-034 SHALL check: alive cell, all eight beats 1 -> COUNT=8, NEXT_STATE=0; alive cell, all beats 0 -> NEXT_STATE=0.
REQ-035 SHALL check: NBR_VALID toggled 0/1 every cycle, and NEXT_READY held 0 for 5 cycles -> same result; NEXT_VALID and NEXT_STATE stable while stalled; START pulses during BUSY have no effect.
REQ-036 SHALL check: RESET_N=0 for one cycle after 4 accepted beats -> IDLE, NBR_READY=0, NEXT_VALID=0; a fresh START then produces the correct result from 8 new beats.

Source files
------------

// File: rtl/conway_pkg.sv
// rtl/conway_pkg.sv - shared FSM state type and neighbourhood sizing for the cell updater
package conway_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } cell_fsm_e;

  localparam int NEIGHBOR_COUNT = 8;
  localparam int COUNT_W        = 4;

endpackage

// File: rtl/cell_rule_eval.sv
// rtl/cell_rule_eval.sv - combinational birth/survive decision for one cell
import conway_pkg::*;

module cell_rule_eval #(
  parameter int unsigned BIRTH_COUNT = 3,
  parameter int unsigned SURVIVE_MIN = 2,
  parameter int unsigned SURVIVE_MAX = 3
) (
  input  logic [COUNT_W-1:0] count_i,
  input  logic               alive_i,
  output logic               next_o
);

  localparam logic [COUNT_W-1:0] BIRTH_C = COUNT_W'(BIRTH_COUNT);
  localparam logic [COUNT_W-1:0] SMIN_C  = COUNT_W'(SURVIVE_MIN);
  localparam logic [COUNT_W-1:0] SMAX_C  = COUNT_W'(SURVIVE_MAX);

  always_comb begin
    if (alive_i) next_o = (count_i >= SMIN_C) && (count_i <= SMAX_C);
    else         next_o = (count_i == BIRTH_C);
  end

endmodule

// File: rtl/cell_update_serial.sv
// rtl/cell_update_serial.sv - serial neighbour accumulator producing next cell state; optional COUNT port via CELL_COUNT_OUT_EN
import conway_pkg::*;

module cell_update_serial #(
  parameter int unsigned BIRTH_COUNT = 3,
  parameter int unsigned SURVIVE_MIN = 2,
  parameter int unsigned SURVIVE_MAX = 3
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               CELL_STATE,
  input  logic               NBR_VALID,
  input  logic               NBR_BIT,
  output logic               NBR_READY,
  output logic               NEXT_VALID,
  output logic               NEXT_STATE,
  input  logic               NEXT_READY,
`ifdef CELL_COUNT_OUT_EN
  output logic [COUNT_W-1:0] COUNT,
`endif
  output logic               BUSY
);

  localparam logic [COUNT_W-1:0] LAST_BEAT = COUNT_W'(NEIGHBOR_COUNT - 1);

  cell_fsm_e          state_q, state_d;
  logic [COUNT_W-1:0] beat_q, beat_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               alive_q, alive_d;
  logic               next_q, next_d;
  logic               rule_next;

  // Fed with count_d so the 8th beat's bit is part of the decision.
  cell_rule_eval #(
    .BIRTH_COUNT(BIRTH_COUNT),
    .SURVIVE_MIN(SURVIVE_MIN),
    .SURVIVE_MAX(SURVIVE_MAX)
  ) u_rule (
    .count_i(count_d),
    .alive_i(alive_q),
    .next_o (rule_next)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      beat_q  <= '0;
      count_q <= '0;
      alive_q <= 1'b0;
      next_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      count_q <= count_d;
      alive_q <= alive_d;
      next_q  <= next_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    count_d = count_q;
    alive_d = alive_q;
    next_d  = next_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          alive_d = CELL_STATE;
          beat_d  = '0;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (NBR_VALID) begin
          count_d = count_q + COUNT_W'(NBR_BIT);
          beat_d  = beat_q + COUNT_W'(1);
          if (beat_q == LAST_BEAT) begin
            next_d  = rule_next;
            state_d = RESULT;
          end
        end
      end
      RESULT: begin
        if (NEXT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign NBR_READY  = (state_q == ACCUM);
  assign NEXT_VALID = (state_q == RESULT);
  assign NEXT_STATE = next_q;
  assign BUSY       = (state_q != IDLE);
`ifdef CELL_COUNT_OUT_EN
  assign COUNT      = count_q;
`endif

endmodule
